axi_mch_ctrl: RTL

AXI_MCH_CTRL -- requirements
Module: axi_mch_ctrl

---
 rtl/axi_mch_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/axi_mch_ctrl.sv
// axi_mch_ctrl: round-robin sharing of one AXI write master and one AXI read
// master among CH_NUM user channels, each channel owning a ring buffer in memory.
// Optional feature macro AXI_MCH_TRUNC_EN: shortens the last burst before the end
// of a ring so it ends exactly at end_addr (disables the early-wrap rule).

// Per-channel ring pointer and candidate burst length
module axi_mch_lane #(
  parameter int BYTE_INCR = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] beg_addr,
  input  logic [29:0] end_addr,
  input  logic [7:0]  burst_len,
  input  logic [7:0]  len,
  input  logic        ch_rst,
  input  logic        upd,
  output logic [29:0] ptr,
  output logic [7:0]  cand_len
);
  logic [29:0] inc;
  logic        wrap;

  // Step of the burst that is actually in flight (latched length)
  assign inc = (30'(len) + 30'd1) * 30'(BYTE_INCR);

`ifdef AXI_MCH_TRUNC_EN
  logic [29:0] room, full_inc;
  assign room     = end_addr - ptr + 30'd1;
  assign full_inc = (30'(burst_len) + 30'd1) * 30'(BYTE_INCR);
  // Short final burst that lands exactly on end_addr
  assign cand_len = (room < full_inc) ? 8'(room / 30'(BYTE_INCR) - 30'd1) : burst_len;
  // Wrap once the burst just completed reached or passed end_addr
  assign wrap     = ({1'b0, ptr} + {1'b0, inc}) > {1'b0, end_addr};
`else
  assign cand_len = burst_len;
  // Early wrap: wrap when a further full burst would not fit before end_addr
  assign wrap     = ptr > (end_addr - (inc << 1) + 30'd1);
`endif

  // Pointer: channel reset wins over a completing burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr <= beg_addr;
    else if (ch_rst) ptr <= beg_addr;
    else if (upd)    ptr <= wrap ? beg_addr : ptr + inc;
  end
endmodule

// One arbitration engine (write or read side)
module axi_mch_eng #(
  parameter int CH_NUM    = 2,
  parameter int CNT_W     = 10,
  parameter int BYTE_INCR = 8,
  parameter int RD_THR    = 512,
  parameter bit IS_RD     = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CH_NUM-1:0][29:0]      beg_addr,
  input  logic [CH_NUM-1:0][29:0]      end_addr,
  input  logic [7:0]                   burst_len,
  input  logic [CH_NUM-1:0]            ch_rst,
  input  logic [CH_NUM-1:0]            mem_en,
  input  logic [CH_NUM-1:0][CNT_W-1:0] fifo_cnt,
  input  logic                         ready,
  input  logic                         done,
  output logic                         start,
  output logic [29:0]                  addr,
  output logic [7:0]                   len,
  output logic [2:0]                   ch
);
  typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;
  state_t state, state_nxt;

  logic [CH_NUM-1:0][29:0] ptr;
  logic [CH_NUM-1:0][7:0]  cand_len;
  logic [CH_NUM-1:0]       elig, upd;
  logic [7:0]              elig8;
  logic [2:0]              rr, pick;
  logic [3:0]              idx;
  logic                    found;
  logic [29:0]             sel_addr;
  logic [7:0]              sel_len;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_lane
    if (IS_RD) begin : g_rd
      assign elig[i] = mem_en[i] && (32'(fifo_cnt[i]) < 32'(RD_THR));
    end else begin : g_wr
      assign elig[i] = mem_en[i] && (32'(fifo_cnt[i]) > 32'(cand_len[i]) + 32'd1);
    end
    assign upd[i] = (state == BUSY) && done && (ch == 3'(i));

    axi_mch_lane #(.BYTE_INCR(BYTE_INCR)) u_lane (
      .clk(clk), .rst_n(rst_n), .beg_addr(beg_addr[i]), .end_addr(end_addr[i]),
      .burst_len(burst_len), .len(len), .ch_rst(ch_rst[i]), .upd(upd[i]),
      .ptr(ptr[i]), .cand_len(cand_len[i])
    );
  end

  assign elig8 = 8'(elig);
  assign start = (state == REQ);

  // Round-robin search starting after the last granted channel
  always_comb begin
    found = 1'b0;
    pick  = 3'd0;
    idx   = 4'd0;
    for (int k = 0; k < CH_NUM; k++) begin
      idx = {1'b0, rr} + 4'(k);
      if (idx >= 4'(CH_NUM)) idx = idx - 4'(CH_NUM);
      if (!found && elig8[idx[2:0]]) begin
        found = 1'b1;
        pick  = idx[2:0];
      end
    end
  end

  // Mux the picked channel's pointer and length
  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (pick == 3'(i)) begin
        sel_addr = ptr[i];
        sel_len  = cand_len[i];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ready && found) state_nxt = REQ;
      REQ:     if (!ready)         state_nxt = BUSY;
      BUSY:    if (done)           state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Grant latch and round-robin pointer, updated only on IDLE->REQ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      len  <= '0;
      ch   <= '0;
      rr   <= '0;
    end else if (state == IDLE && state_nxt == REQ) begin
      addr <= sel_addr;
      len  <= sel_len;
      ch   <= pick;
      rr   <= (pick == 3'(CH_NUM - 1)) ? 3'd0 : pick + 3'd1;
    end
  end
endmodule

// Top: independent write and read engines
module axi_mch_ctrl #(
  parameter int CH_NUM    = 2,
  parameter int CNT_W     = 10,
  parameter int BYTE_INCR = 8,
  parameter int RD_THR    = 512
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CH_NUM*30-1:0]    wr_beg_addr,
  input  logic [CH_NUM*30-1:0]    wr_end_addr,
  input  logic [7:0]              wr_burst_len,
  input  logic [CH_NUM-1:0]       wr_ch_rst,
  input  logic [CH_NUM*CNT_W-1:0] wr_fifo_cnt,
  input  logic                    axi_wr_ready,
  input  logic                    axi_wr_done,
  output logic                    axi_wr_start,
  output logic [29:0]             axi_wr_addr,
  output logic [7:0]              axi_wr_len,
  output logic [2:0]              axi_wr_ch,
  input  logic [CH_NUM*30-1:0]    rd_beg_addr,
  input  logic [CH_NUM*30-1:0]    rd_end_addr,
  input  logic [7:0]              rd_burst_len,
  input  logic [CH_NUM-1:0]       rd_ch_rst,
  input  logic [CH_NUM-1:0]       rd_mem_enable,
  input  logic [CH_NUM*CNT_W-1:0] rd_fifo_cnt,
  input  logic                    axi_rd_ready,
  input  logic                    axi_rd_done,
  output logic                    axi_rd_start,
  output logic [29:0]             axi_rd_addr,
  output logic [7:0]              axi_rd_len,
  output logic [2:0]              axi_rd_ch
);
  axi_mch_eng #(.CH_NUM(CH_NUM), .CNT_W(CNT_W), .BYTE_INCR(BYTE_INCR),
                .RD_THR(RD_THR), .IS_RD(1'b0)) u_wr (
    .clk(clk), .rst_n(rst_n), .beg_addr(wr_beg_addr), .end_addr(wr_end_addr),
    .burst_len(wr_burst_len), .ch_rst(wr_ch_rst), .mem_en({CH_NUM{1'b1}}),
    .fifo_cnt(wr_fifo_cnt), .ready(axi_wr_ready), .done(axi_wr_done),
    .start(axi_wr_start), .addr(axi_wr_addr), .len(axi_wr_len), .ch(axi_wr_ch)
  );

  axi_mch_eng #(.CH_NUM(CH_NUM), .CNT_W(CNT_W), .BYTE_INCR(BYTE_INCR),
                .RD_THR(RD_THR), .IS_RD(1'b1)) u_rd (
    .clk(clk), .rst_n(rst_n), .beg_addr(rd_beg_addr), .end_addr(rd_end_addr),
    .burst_len(rd_burst_len), .ch_rst(rd_ch_rst), .mem_en(rd_mem_enable),
    .fifo_cnt(rd_fifo_cnt), .ready(axi_rd_ready), .done(axi_rd_done),
    .start(axi_rd_start), .addr(axi_rd_addr), .len(axi_rd_len), .ch(axi_rd_ch)
  );
endmodule
